wiscsc15_fetch: RTL

- Instruction fetch unit for the WISC-SC15 core, i.e. the producer side of the opcode stream that the control decoder consumes.
- Holds the PC, issues word reads to instruction memory over a req/ack handshake, and buffers returned instructions in a small FIFO.
- Presents the buffered instructions to decode with a valid/ready handshake.
- Accepts redirects from branch, call and return resolution. A redirect flushes the FIFO and squashes any in-flight read.

---
 rtl/wiscsc15_fetch.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/wiscsc15_fetch.sv
// WISC-SC15 instruction fetch unit: PC, imem req/ack, instruction FIFO, redirect handling.
// Optional fetch statistics counters enabled by defining WISCSC15_FETCH_STATS_EN.
module wiscsc15_fetch #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int unsigned DEPTH    = 2,
  parameter logic [3:0]  HALT_OP  = 4'hF
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [15:0] instr,
  output logic [3:0]  opcode,
  output logic [15:0] instr_pc,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_target,
  output logic        halted
`ifdef WISCSC15_FETCH_STATS_EN
  ,
  output logic [15:0] stat_fetched,
  output logic [15:0] stat_squashed
`endif
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [CntW-1:0] DepthC = CntW'(DEPTH);

  typedef enum logic [1:0] {StRun, StDrain, StHalt} state_e;

  state_e            state_q, state_d;
  logic [15:0]       pc_q, pc_d;
  logic [15:0]       target_q, target_d;
  logic              req_q, req_d;
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   count_q;
  logic [15:0]       data_mem [DEPTH];
  logic [15:0]       pc_mem   [DEPTH];

  logic ack_acc;
  logic push;
  logic squash;
  logic pop;

  // An ack only counts while a request is actually outstanding.
  assign ack_acc = imem_ack & req_q;
  assign pop     = instr_valid & instr_ready;

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign instr_valid = (count_q != '0);
  assign instr       = instr_valid ? data_mem[rd_ptr_q] : 16'h0000;
  assign instr_pc    = instr_valid ? pc_mem[rd_ptr_q] : 16'h0000;
  assign opcode      = instr[15:12];
  assign halted      = (state_q == StHalt);

  // Next-state, PC and request control; redirect has highest priority.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    target_d = target_q;
    req_d    = req_q;
    push     = 1'b0;
    squash   = 1'b0;
    if (redirect_valid) begin
      target_d = redirect_target;
      if (ack_acc) begin
        squash  = 1'b1;
        pc_d    = redirect_target;
        req_d   = 1'b0;
        state_d = StRun;
      end else if (req_q) begin
        // Address must stay stable until the ack, so the target waits in target_q.
        state_d = StDrain;
      end else begin
        pc_d    = redirect_target;
        state_d = StRun;
      end
    end else begin
      case (state_q)
        StRun: begin
          if (ack_acc) begin
            push  = 1'b1;
            pc_d  = pc_q + 16'd1;
            req_d = 1'b0;
            if (imem_rdata[15:12] == HALT_OP) state_d = StHalt;
          end else if (!req_q && (count_q < DepthC)) begin
            req_d = 1'b1;
          end
        end
        StDrain: begin
          if (ack_acc) begin
            squash  = 1'b1;
            pc_d    = target_q;
            req_d   = 1'b0;
            state_d = StRun;
          end
        end
        default: ;
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StRun;
      pc_q     <= RESET_PC;
      target_q <= RESET_PC;
      req_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      target_q <= target_d;
      req_q    <= req_d;
    end
  end

  // FIFO pointers and occupancy; a redirect flushes everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (redirect_valid) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: ;
      endcase
    end
  end

  // FIFO storage; contents are don't-care while the entry is invalid.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr_q] <= imem_rdata;
      pc_mem[wr_ptr_q]   <= pc_q;
    end
  end

`ifdef WISCSC15_FETCH_STATS_EN
  // Saturating counts of accepted and discarded acks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_fetched  <= 16'h0000;
      stat_squashed <= 16'h0000;
    end else begin
      if (push && (stat_fetched != 16'hFFFF))    stat_fetched  <= stat_fetched + 16'd1;
      if (squash && (stat_squashed != 16'hFFFF)) stat_squashed <= stat_squashed + 16'd1;
    end
  end
`endif

endmodule
